// File: rtl/prim_and2_blank_ctrl_if.sv
// Bundle between the blanking controller and its requesters / the gated AND array.
// The slave modport is the controller; the master modport drives requests and watches grants.
interface prim_and2_blank_ctrl_if #(
  parameter int NumReq = 4,
  parameter int Width  = 32
);
  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic [NumReq-1:0] req_i;
  logic [NumReq-1:0] done_i;
  logic [NumReq-1:0] gnt_o;
  logic [Width-1:0]  blank_en_o;
  logic [IdxW-1:0]   owner_idx_o;
  logic              busy_o;
  logic              timeout_o;

  modport slave (
    input  req_i,
    input  done_i,
    output gnt_o,
    output blank_en_o,
    output owner_idx_o,
    output busy_o,
    output timeout_o
  );

  modport master (
    output req_i,
    output done_i,
    input  gnt_o,
    input  blank_en_o,
    input  owner_idx_o,
    input  busy_o,
    input  timeout_o
  );
endinterface

// File: rtl/prim_and2_blank_ctrl.sv
// Round-robin owner of a shared AND-gated blanking datapath: arm cycle, forced zero gap, optional hold timeout.
// Latency: request in IDLE to enable open is 2 cycles; requesters wait by holding req_i until granted.
module prim_and2_blank_ctrl #(
  parameter int NumReq    = 4,
  parameter int Width     = 32,
  parameter int GapCycles = 2,
  parameter int MaxHold   = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  prim_and2_blank_ctrl_if.slave bus
);
  localparam int IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int HoldW = (MaxHold > 0) ? $clog2(MaxHold + 1) : 1;

  localparam logic [HoldW-1:0] HoldLast = HoldW'(MaxHold);
  localparam logic [7:0]       GapLast  = 8'(GapCycles);
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(NumReq - 1);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    ACTIVE,
    GAP
  } state_t;

  state_t            state_q, state_d;
  logic [NumReq-1:0] gnt_q, gnt_d;
  logic              blank_q, blank_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic              busy_q, busy_d;
  logic              timeout_q, timeout_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [7:0]        gap_q, gap_d;

  logic              win_vld;
  logic [IdxW-1:0]   win_idx;
  logic              owner_rel;
  logic              hold_expired;

  // Scan downwards so the closest set bit at or after the pointer is the last one written.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (bus.req_i[(int'(ptr_q) + i) % NumReq]) begin
        win_vld = 1'b1;
        win_idx = IdxW'((int'(ptr_q) + i) % NumReq);
      end
    end
  end

  assign owner_rel    = bus.done_i[owner_q] | ~bus.req_i[owner_q];
  assign hold_expired = (MaxHold != 0) && (hold_q == HoldLast);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    blank_d   = 1'b0;
    owner_d   = owner_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    gap_d     = gap_q;

    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = ARM;
          gnt_d   = {{(NumReq-1){1'b0}}, 1'b1} << win_idx;
          owner_d = win_idx;
          busy_d  = 1'b1;
        end
      end

      ARM: begin
        state_d = ACTIVE;
        blank_d = 1'b1;
        hold_d  = HoldW'(1);
      end

      ACTIVE: begin
        if (owner_rel || hold_expired) begin
          state_d   = GAP;
          gnt_d     = '0;
          gap_d     = 8'd1;
          ptr_d     = (owner_q == IdxLast) ? '0 : owner_q + IdxW'(1);
          // A release landing on the expiry cycle wins: no timeout reported.
          timeout_d = hold_expired && !owner_rel;
        end else begin
          blank_d = 1'b1;
          if (hold_q != '1) begin
            hold_d = hold_q + HoldW'(1);
          end
        end
      end

      GAP: begin
        if (gap_q == GapLast) begin
          if (win_vld) begin
            state_d = ARM;
            gnt_d   = {{(NumReq-1){1'b0}}, 1'b1} << win_idx;
            owner_d = win_idx;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      blank_q   <= 1'b0;
      owner_q   <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      ptr_q     <= '0;
      hold_q    <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      blank_q   <= blank_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gap_q     <= gap_d;
    end
  end

  assign bus.gnt_o       = gnt_q;
  assign bus.blank_en_o  = {Width{blank_q}};
  assign bus.owner_idx_o = owner_q;
  assign bus.busy_o      = busy_q;
  assign bus.timeout_o   = timeout_q;

  a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(bus.gnt_o));
  a_blank_uniform : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (bus.blank_en_o == '0) || (bus.blank_en_o == '1));
  a_blank_active : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (bus.blank_en_o != '0) |-> (state_q == ACTIVE));
endmodule

// File: tb/tb_prim_and2_blank_ctrl.sv
// Scoreboarded bench: each grant's owner, open length and timeout flag are queued when driven
// and compared when the enable closes; directed checks cover cycle timing and async reset.
module tb_prim_and2_blank_ctrl;
  localparam int NumReq    = 4;
  localparam int Width     = 32;
  localparam int GapCycles = 2;
  localparam int MaxHold   = 64;

  typedef struct {
    int owner;
    int len;
    int to;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  exp_t exp_q[$];

  prim_and2_blank_ctrl_if #(.NumReq(NumReq), .Width(Width)) bus ();

  prim_and2_blank_ctrl #(
    .NumReq   (NumReq),
    .Width    (Width),
    .GapCycles(GapCycles),
    .MaxHold  (MaxHold)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: measures each open window and the zero-enable run preceding it.
  int  mon_len;
  int  mon_zero;
  int  mon_owner;
  bit  mon_in_act;
  bit  mon_have_prev;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_in_act    = 1'b0;
      mon_have_prev = 1'b0;
      mon_zero      = 0;
      mon_len       = 0;
    end else if (bus.blank_en_o != '0) begin
      if (!mon_in_act) begin
        mon_in_act = 1'b1;
        mon_len    = 0;
        mon_owner  = int'(bus.owner_idx_o);
        chk("blank_all_ones", bus.blank_en_o, 64'hFFFF_FFFF);
        if (mon_have_prev) chk("gap_zero_cycles_ok", mon_zero >= GapCycles, 1);
      end
      mon_len++;
    end else begin
      if (mon_in_act) begin
        mon_in_act = 1'b0;
        chk("sb_has_entry", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_owner", mon_owner, e.owner);
          chk("sb_open_len", mon_len, e.len);
          chk("sb_timeout", bus.timeout_o, e.to);
        end
        mon_have_prev = 1'b1;
        mon_zero      = 0;
      end
      mon_zero++;
    end
  end

  task automatic wait_open(input int budget);
    int n;
    n = 0;
    while (bus.blank_en_o == '0 && n < budget) begin
      tick();
      n++;
    end
    chk("open_within_budget", bus.blank_en_o != '0, 1);
  endtask

  // Expect a grant to owner, hold it open for hold cycles, then release by done or by dropping req.
  task automatic grant_release(input int owner, input int hold, input bit drop, input logic [3:0] new_req);
    exp_t e;
    e.owner = owner;
    e.len   = hold;
    e.to    = 0;
    exp_q.push_back(e);
    wait_open(40);
    chk("gnt_onehot_owner", bus.gnt_o, 4'b0001 << owner);
    repeat (hold - 1) tick();
    if (!drop) bus.done_i = 4'b0001 << owner;
    bus.req_i = new_req;
    tick();
    bus.done_i = '0;
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst_n       = 1'b0;
    bus.req_i   = '0;
    bus.done_i  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", bus.gnt_o, 0);
    chk("rst_blank", bus.blank_en_o, 0);
    chk("rst_owner", bus.owner_idx_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_timeout", bus.timeout_o, 0);
    rst_n = 1'b1;
    tick();

    // Single request: ARM one cycle, then open.
    bus.req_i = 4'b0100;
    tick();
    chk("arm_gnt", bus.gnt_o, 4'b0100);
    chk("arm_blank_closed", bus.blank_en_o, 0);
    chk("arm_owner", bus.owner_idx_o, 2);
    chk("arm_busy", bus.busy_o, 1);
    tick();
    chk("open_blank", bus.blank_en_o, 32'hFFFF_FFFF);
    chk("open_gnt", bus.gnt_o, 4'b0100);

    // Owner 2 releases while 3 and 0 wait: two zero cycles, then pointer=3 picks 3.
    exp_q.push_back('{owner: 2, len: 1, to: 0});
    bus.req_i  = 4'b1101;
    bus.done_i = 4'b0100;
    tick();
    bus.done_i = '0;
    bus.req_i  = 4'b1001;
    chk("gap1_gnt", bus.gnt_o, 0);
    chk("gap1_blank", bus.blank_en_o, 0);
    chk("gap1_busy", bus.busy_o, 1);
    tick();
    chk("gap2_gnt", bus.gnt_o, 0);
    chk("gap2_blank", bus.blank_en_o, 0);
    tick();
    chk("rearb_gnt", bus.gnt_o, 4'b1000);
    chk("rearb_owner", bus.owner_idx_o, 3);
    grant_release(3, 3, 1'b0, 4'b0001);
    grant_release(0, 2, 1'b0, 4'b0000);
    repeat (4) tick();
    chk("idle_busy", bus.busy_o, 0);

    // Non-owner done is ignored; owner dropping req releases like done.
    exp_q.push_back('{owner: 0, len: 3, to: 0});
    bus.req_i = 4'b0001;
    wait_open(10);
    tick();
    bus.done_i = 4'b0010;
    tick();
    bus.done_i = '0;
    chk("nonowner_blank", bus.blank_en_o, 32'hFFFF_FFFF);
    chk("nonowner_gnt", bus.gnt_o, 4'b0001);
    bus.req_i = 4'b0000;
    tick();
    chk("reqdrop_blank", bus.blank_en_o, 0);
    chk("reqdrop_gnt", bus.gnt_o, 0);
    repeat (4) tick();

    // Hold timeout: open exactly MaxHold cycles, single-cycle timeout pulse on GAP entry.
    exp_q.push_back('{owner: 0, len: MaxHold, to: 1});
    bus.req_i = 4'b0001;
    wait_open(10);
    begin
      int n;
      int guard;
      n     = 1;
      guard = 0;
      tick();
      while (bus.blank_en_o != '0 && guard < 200) begin
        n++;
        guard++;
        tick();
      end
      chk("timeout_hold_len", n, MaxHold);
      chk("timeout_pulse", bus.timeout_o, 1);
      chk("timeout_gnt", bus.gnt_o, 0);
      tick();
      chk("timeout_single", bus.timeout_o, 0);
    end
    // Same hold but done lands on the expiry cycle: normal release.
    grant_release(0, MaxHold, 1'b0, 4'b0000);
    repeat (5) tick();

    // Asynchronous reset in the middle of ACTIVE.
    bus.req_i = 4'b0001;
    wait_open(10);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_blank", bus.blank_en_o, 0);
    chk("async_gnt", bus.gnt_o, 0);
    chk("async_busy", bus.busy_o, 0);
    bus.req_i = '0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_busy", bus.busy_o, 0);
    chk("post_rst_gnt", bus.gnt_o, 0);
    chk("post_rst_owner", bus.owner_idx_o, 0);

    // All four held: strict rotation from pointer 0.
    bus.req_i = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      grant_release(k % NumReq, 1 + (k % 3), 1'b0, (k == 7) ? 4'b0000 : 4'b1111);
    end
    repeat (6) tick();
    chk("sb_drained", exp_q.size(), 0);
    chk("final_busy", bus.busy_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
